// File: rtl/display_sel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_sel_pkg                                                      |
// | Shared state encoding and index-width helper for the display select. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package display_sel_pkg;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_FROZEN  = 2'd2
  } disp_state_t;

  // Index width for an n-entry selector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sel_index_stepper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sel_index_stepper                                                    |
// | Wrap-around index register advanced by a one-cycle step pulse.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module sel_index_stepper
  import display_sel_pkg::*;
#(
  parameter int N = 3,
  parameter int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  output logic [W-1:0] idx,
  output logic         changed
);

  localparam logic [W-1:0] c_last = W'(N - 1);

  logic [W-1:0] r_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
    end else if (step) begin
      r_idx <= (r_idx == c_last) ? '0 : r_idx + W'(1);
    end
  end

  assign idx     = r_idx;
  assign changed = step;

endmodule
`default_nettype wire

// File: rtl/display_select_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_select_engine                                                |
// | Source/type selection, zero offset, hold and rate-limited hand-off   |
// | of the displayed value to the BIN->BCD stage.                        |
// | Optional macro DISP_AUTO_SCROLL_EN: periodic automatic source step.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module display_select_engine
  import display_sel_pkg::*;
#(
  parameter int         N_SRC       = 3,
  parameter int         N_TYPE      = 3,
  parameter int         DATA_W      = 16,
  parameter int         REFRESH_CYC = 100000,
  parameter int         DP_TYPE     = 2,
  parameter logic [3:0] DP_PATTERN  = 4'b1000
`ifdef DISP_AUTO_SCROLL_EN
  ,
  parameter int         SCROLL_CYC  = 200000000
`endif
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_SRC*N_TYPE*DATA_W-1:0]  data_in,
  input  logic                            btn_next_src,
  input  logic                            btn_next_type,
  input  logic                            btn_hold,
  input  logic                            btn_zero,
  input  logic                            dp_sel,
  output logic [DATA_W-1:0]               out_value,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [3:0]                      decimal_pt,
  output logic [idx_w(N_SRC)-1:0]         cur_src,
  output logic [idx_w(N_TYPE)-1:0]        cur_type,
  output logic                            hold_active
);

  localparam int SRC_W  = idx_w(N_SRC);
  localparam int TYPE_W = idx_w(N_TYPE);
  localparam int CNT_W  = idx_w(REFRESH_CYC);
  localparam logic [CNT_W-1:0] c_reload = CNT_W'(REFRESH_CYC - 1);

  logic [SRC_W-1:0]  w_src_idx;
  logic [TYPE_W-1:0] w_type_idx;
  logic              w_src_step;
  logic              w_src_chg;
  logic              w_type_chg;
  logic              w_idx_chg;
  logic              w_scroll_tick;
  int                w_flat;
  logic [DATA_W-1:0] w_sel;
  logic [DATA_W-1:0] w_disp;

  disp_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_offset;
  logic [DATA_W-1:0] r_out_value;
  logic              r_out_valid;
  logic              r_hold;
  logic [3:0]        r_dp;

  assign w_src_step = btn_next_src | w_scroll_tick;
  assign w_idx_chg  = w_src_chg | w_type_chg;

  sel_index_stepper #(.N(N_SRC), .W(SRC_W)) u_src_step (
    .clk     (clk),
    .reset   (reset),
    .step    (w_src_step),
    .idx     (w_src_idx),
    .changed (w_src_chg)
  );

  sel_index_stepper #(.N(N_TYPE), .W(TYPE_W)) u_type_step (
    .clk     (clk),
    .reset   (reset),
    .step    (btn_next_type),
    .idx     (w_type_idx),
    .changed (w_type_chg)
  );

`ifdef DISP_AUTO_SCROLL_EN
  localparam int SCR_W = idx_w(SCROLL_CYC);
  localparam logic [SCR_W-1:0] c_scroll_last = SCR_W'(SCROLL_CYC - 1);

  logic [SCR_W-1:0] r_scroll_cnt;
  logic             w_any_btn;

  assign w_any_btn     = btn_next_src | btn_next_type | btn_hold | btn_zero;
  assign w_scroll_tick = !r_hold && !w_any_btn && (r_scroll_cnt == c_scroll_last);

  // Scroll period restarts on any user interaction and is paused while held.
  always_ff @(posedge clk) begin
    if (reset || w_any_btn || r_hold || w_scroll_tick) begin
      r_scroll_cnt <= '0;
    end else begin
      r_scroll_cnt <= r_scroll_cnt + SCR_W'(1);
    end
  end
`else
  assign w_scroll_tick = 1'b0;
`endif

  always_comb begin
    w_flat = int'(w_src_idx) * N_TYPE + int'(w_type_idx);
    w_sel  = '0;
    for (int i = 0; i < N_SRC * N_TYPE; i++) begin
      if (i == w_flat) begin
        w_sel = data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_disp = (w_sel > r_offset) ? (w_sel - r_offset) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_WAIT;
      r_cnt       <= '0;
      r_offset    <= '0;
      r_out_value <= '0;
      r_out_valid <= 1'b0;
      r_hold      <= 1'b0;
      r_dp        <= 4'b0000;
    end else begin
      r_dp <= ((int'(w_type_idx) == DP_TYPE) && dp_sel) ? DP_PATTERN : 4'b0000;
      // A selection change overrides zero/hold and forces an immediate resample.
      if (w_idx_chg) begin
        r_offset    <= '0;
        r_hold      <= 1'b0;
        r_state     <= ST_WAIT;
        r_cnt       <= '0;
        r_out_valid <= 1'b0;
      end else begin
        if (btn_zero) r_offset <= w_sel;
        if (btn_hold) r_hold   <= !r_hold;
        case (r_state)
          ST_WAIT: begin
            if (r_cnt == '0) begin
              r_out_value <= w_disp;
              r_out_valid <= 1'b1;
              r_cnt       <= c_reload;
              r_state     <= ST_PRESENT;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          ST_PRESENT: begin
            if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
            if (r_out_valid && out_ready) begin
              r_out_valid <= 1'b0;
              r_state     <= r_hold ? ST_FROZEN : ST_WAIT;
            end
          end
          ST_FROZEN: begin
            if (btn_hold && r_hold) begin
              r_state <= ST_WAIT;
              r_cnt   <= '0;
            end
          end
          default: r_state <= ST_WAIT;
        endcase
      end
    end
  end

  assign out_value   = r_out_value;
  assign out_valid   = r_out_valid;
  assign decimal_pt  = r_dp;
  assign cur_src     = w_src_idx;
  assign cur_type    = w_type_idx;
  assign hold_active = r_hold;

endmodule
`default_nettype wire

// File: tb/tb_display_select_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_display_select_engine                                             |
// | Scoreboard bench: directed stimulus queues expected words, a monitor |
// | pops and compares them on every accepted handshake.                  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_display_select_engine;

  localparam int N_SRC       = 3;
  localparam int N_TYPE      = 3;
  localparam int DATA_W      = 16;
  localparam int REFRESH_CYC = 4;
  localparam int DP_TYPE     = 2;

  typedef struct {
    logic [DATA_W-1:0] val;
    int                cyc;
  } exp_t;

  logic                           clk = 1'b0;
  logic                           reset = 1'b1;
  logic [N_SRC*N_TYPE*DATA_W-1:0] data_in = '0;
  logic                           btn_next_src = 1'b0;
  logic                           btn_next_type = 1'b0;
  logic                           btn_hold = 1'b0;
  logic                           btn_zero = 1'b0;
  logic                           dp_sel = 1'b0;
  logic [DATA_W-1:0]              out_value;
  logic                           out_valid;
  logic                           out_ready = 1'b0;
  logic [3:0]                     decimal_pt;
  logic [1:0]                     cur_src;
  logic [1:0]                     cur_type;
  logic                           hold_active;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rel_cyc;
  exp_t exp_q[$];
  logic [DATA_W-1:0] src_word [3];

  display_select_engine #(
    .N_SRC       (N_SRC),
    .N_TYPE      (N_TYPE),
    .DATA_W      (DATA_W),
    .REFRESH_CYC (REFRESH_CYC),
    .DP_TYPE     (DP_TYPE),
    .DP_PATTERN  (4'b1000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .btn_next_src  (btn_next_src),
    .btn_next_type (btn_next_type),
    .btn_hold      (btn_hold),
    .btn_zero      (btn_zero),
    .dp_sel        (dp_sel),
    .out_value     (out_value),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .decimal_pt    (decimal_pt),
    .cur_src       (cur_src),
    .cur_type      (cur_type),
    .hold_active   (hold_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endfunction

  task automatic set_word(input int idx, input logic [DATA_W-1:0] v);
    data_in[idx*DATA_W +: DATA_W] = v;
  endtask

  task automatic pulse(input logic s, input logic t, input logic h, input logic z);
    @(posedge clk); #1;
    btn_next_src = s; btn_next_type = t; btn_hold = h; btn_zero = z;
    @(posedge clk); #1;
    btn_next_src = 1'b0; btn_next_type = 1'b0; btn_hold = 1'b0; btn_zero = 1'b0;
  endtask

  // Queue the expected word, wait for the DUT to offer one, accept it once.
  task automatic expect_word(input logic [DATA_W-1:0] v);
    exp_t e;
    bit   got;
    e.val = v;
    e.cyc = -1;
    exp_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk); #1;
      if (out_valid) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: out_valid 0 required 1 (word 0x%0h)", v);
      exp_q.delete(exp_q.size() - 1);
    end else begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: actual 0x%0h required none", out_value);
        end else begin
          e = exp_q.pop_front();
          check("word_value", out_value, e.val);
          if (e.cyc >= 0) check("word_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    exp_t e;
    bit   got;
    src_word[0] = 16'h0123;
    src_word[1] = 16'h0456;
    src_word[2] = 16'h0789;
    for (int i = 0; i < N_SRC * N_TYPE; i++) set_word(i, 16'h1000 + 16'(i));
    set_word(0, src_word[0]);
    set_word(3, src_word[1]);
    set_word(6, src_word[2]);
    set_word(4, 16'h0444);
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_value", out_value, 0);
    check("rst_dp", decimal_pt, 0);
    check("rst_src", cur_src, 0);
    check("rst_type", cur_type, 0);
    check("rst_hold", hold_active, 0);

    // Free-running refresh with a sink that is always ready.
    rel_cyc = cyc;
    for (int k = 0; k < 3; k++) begin
      e.val = 16'h0123;
      e.cyc = rel_cyc + 1 + k * REFRESH_CYC;
      exp_q.push_back(e);
    end
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b0;

    for (int k = 1; k <= 3; k++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      check("cur_src_step", cur_src, k % 3);
      expect_word(src_word[k % 3]);
    end

    // Zero request coinciding with a source step must be dropped.
    set_word(3, 16'd500);
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    check("cur_src_combo", cur_src, 1);
    expect_word(16'd500);

    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    set_word(3, 16'd520);
    expect_word(16'd20);
    set_word(3, 16'd480);
    expect_word(16'd0);

    // Back-pressure: presented word must not move while data changes.
    set_word(3, 16'd600);
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      set_word(3, 16'(700 + k));
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1);
      check("stall_value", out_value, 100);
    end
    expect_word(16'd100);

    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("hold_set", hold_active, 1);
    expect_word(16'd209);
    out_ready = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      check("frozen_valid", out_valid, 0);
      check("frozen_value", out_value, 209);
    end
    out_ready = 1'b0;

    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("hold_clear", hold_active, 0);
    check("cur_type_step", cur_type, 1);
    expect_word(16'h0444);

    dp_sel = 1'b1;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("cur_type_dp", cur_type, 2);
    check("dp_latency", decimal_pt, 4'b0000);
    @(posedge clk); #1;
    check("dp_on", decimal_pt, 4'b1000);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("cur_type_wrap", cur_type, 0);
    check("dp_hold_1cyc", decimal_pt, 4'b1000);
    @(posedge clk); #1;
    check("dp_off", decimal_pt, 4'b0000);

    // Reset while a word is pending must simply drop it.
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (out_valid) got = 1'b1;
    end
    check("pending_before_reset", got, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_drops_valid", out_valid, 0);
    check("reset_src", cur_src, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
